// File: rtl/display_scan_controller.sv
// Six-digit multiplexed display scanner: per-slot GUARD/ON/OFF sequencing with
// frame-latched brightness, per-digit blink, global blanking and colon drive.
module display_scan_controller #(
   parameter int SCAN_DIV     = 16,
   parameter int BLANK_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [41:0] seg_in,
   input  logic        colon_in,
   input  logic [1:0]  brightness,
   input  logic [5:0]  blink_mask,
   input  logic        blink_phase,
   input  logic        blank_req,
   output logic [6:0]  seg_out,
   output logic        colon_out,
   output logic [5:0]  dig_en,
   output logic        frame_start
);

   localparam int CW = $clog2(SCAN_DIV);
   localparam int W  = SCAN_DIV - BLANK_CYCLES;

   typedef enum logic [1:0] {
      ST_GUARD = 2'd0,
      ST_ON    = 2'd1,
      ST_OFF   = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_next_state;
   logic            r_active;
   logic [2:0]      r_slot;
   logic [CW-1:0]   r_cnt;
   logic [1:0]      r_bright;
   logic            r_blink_off;
   logic            r_colon_s;
   logic [6:0]      r_seg;
   logic [5:0]      r_dig;
   logic            r_colon;
   logic            r_frame;

   logic [2:0]      w_next_slot;
   logic [CW-1:0]   w_next_cnt;
   logic            w_slot_start;
   logic            w_frame_start;
   logic [1:0]      w_bright_next;
   logic [31:0]     w_on_len;
   logic [31:0]     w_on_end;
   logic [31:0]     w_next_cnt32;
   logic [5:0]      w_digit_sel;
   logic            w_blink_next;
   logic            w_colon_next;
   logic [6:0]      w_seg_next;
   logic [6:0]      w_slot_pattern;
   logic [5:0]      w_dig_next;

   // Position of the output cycle about to be produced; the first cycle out of
   // reset is slot 0 c = 0 rather than an increment.
   always_comb begin
      w_next_slot = r_slot;
      w_next_cnt  = r_cnt;
      if (!r_active) begin
         w_next_slot = 3'd0;
         w_next_cnt  = '0;
      end else if (r_cnt == CW'(SCAN_DIV - 1)) begin
         w_next_cnt  = '0;
         w_next_slot = (r_slot == 3'd5) ? 3'd0 : r_slot + 3'd1;
      end else begin
         w_next_cnt  = r_cnt + CW'(1);
         w_next_slot = r_slot;
      end
   end

   assign w_slot_start  = (w_next_cnt == '0);
   assign w_frame_start = w_slot_start && (w_next_slot == 3'd0);
   assign w_bright_next = w_frame_start ? brightness : r_bright;
   assign w_on_len      = (32'(W) * (32'(w_bright_next) + 32'd1)) >> 2;
   assign w_on_end      = 32'(BLANK_CYCLES) + w_on_len;
   assign w_next_cnt32  = 32'(w_next_cnt);
   assign w_digit_sel   = 6'b100000 >> w_next_slot;
   assign w_blink_next  = w_slot_start ? (|(blink_mask & w_digit_sel) & ~blink_phase)
                                       : r_blink_off;
   assign w_colon_next  = w_slot_start ? colon_in : r_colon_s;

   // Pattern for the slot being entered; h1 occupies the top of seg_in.
   always_comb begin
      w_slot_pattern = 7'd0;
      case (w_next_slot)
         3'd0:    w_slot_pattern = seg_in[41:35];
         3'd1:    w_slot_pattern = seg_in[34:28];
         3'd2:    w_slot_pattern = seg_in[27:21];
         3'd3:    w_slot_pattern = seg_in[20:14];
         3'd4:    w_slot_pattern = seg_in[13:7];
         3'd5:    w_slot_pattern = seg_in[6:0];
         default: w_slot_pattern = 7'd0;
      endcase
   end

   assign w_seg_next = w_slot_start ? w_slot_pattern : r_seg;

   // Slot FSM next state: every slot opens in GUARD, which keeps the enables
   // dark while the shared segment bus switches to the new pattern.
   always_comb begin
      w_next_state = r_state;
      if (w_slot_start) begin
         w_next_state = ST_GUARD;
      end else begin
         case (r_state)
            ST_GUARD: begin
               if (w_next_cnt32 == 32'(BLANK_CYCLES)) begin
                  w_next_state = (w_on_len == 32'd0) ? ST_OFF : ST_ON;
               end else begin
                  w_next_state = ST_GUARD;
               end
            end
            ST_ON: begin
               if (w_next_cnt32 == w_on_end) begin
                  w_next_state = ST_OFF;
               end else begin
                  w_next_state = ST_ON;
               end
            end
            ST_OFF:  w_next_state = ST_OFF;
            default: w_next_state = ST_GUARD;
         endcase
      end
   end

   // Enable for the produced cycle; blanking acts one cycle after its request.
   always_comb begin
      w_dig_next = 6'd0;
      if ((w_next_state == ST_ON) && !w_blink_next && !blank_req) begin
         w_dig_next = w_digit_sel;
      end else begin
         w_dig_next = 6'd0;
      end
   end

   // State, scan position and all registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_GUARD;
         r_active    <= 1'b0;
         r_slot      <= 3'd0;
         r_cnt       <= '0;
         r_bright    <= 2'd0;
         r_blink_off <= 1'b0;
         r_colon_s   <= 1'b0;
         r_seg       <= 7'd0;
         r_dig       <= 6'd0;
         r_colon     <= 1'b0;
         r_frame     <= 1'b0;
      end else begin
         r_state     <= w_next_state;
         r_active    <= 1'b1;
         r_slot      <= w_next_slot;
         r_cnt       <= w_next_cnt;
         r_bright    <= w_bright_next;
         r_blink_off <= w_blink_next;
         r_colon_s   <= w_colon_next;
         r_seg       <= w_seg_next;
         r_dig       <= w_dig_next;
         r_colon     <= w_colon_next & w_dig_next[4];
         r_frame     <= w_frame_start;
      end
   end

   assign seg_out     = r_seg;
   assign dig_en      = r_dig;
   assign colon_out   = r_colon;
   assign frame_start = r_frame;

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller with default parameters
// (16 cycles per slot, 2 guard cycles, 96-cycle frame).
module tb_display_scan_controller;

   logic        clk;
   logic        rst;
   logic [41:0] seg_in;
   logic        colon_in;
   logic [1:0]  brightness;
   logic [5:0]  blink_mask;
   logic        blink_phase;
   logic        blank_req;
   logic [6:0]  seg_out;
   logic        colon_out;
   logic [5:0]  dig_en;
   logic        frame_start;

   int n_checks = 0;
   int n_fail   = 0;

   logic [5:0] cap_dig [0:95];
   logic [6:0] cap_seg [0:95];
   logic       cap_col [0:95];
   logic       cap_fs  [0:95];
   logic [6:0] exp_seg [0:5];

   display_scan_controller #(.SCAN_DIV(16), .BLANK_CYCLES(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .seg_in      (seg_in),
      .colon_in    (colon_in),
      .brightness  (brightness),
      .blink_mask  (blink_mask),
      .blink_phase (blink_phase),
      .blank_req   (blank_req),
      .seg_out     (seg_out),
      .colon_out   (colon_out),
      .dig_en      (dig_en),
      .frame_start (frame_start)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int idx, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s @%0d: observed %h expected %h", tag, idx, obs, exp);
      end
   endtask

   // Capture one frame starting at the current negedge, applying per-frame stimulus.
   task automatic run_frame(input int f);
      for (int i = 0; i < 96; i++) begin
         cap_dig[i] = dig_en;
         cap_seg[i] = seg_out;
         cap_col[i] = colon_out;
         cap_fs[i]  = frame_start;
         chk("onehot0", i, 64'($onehot0(dig_en)), 64'd1);
         if (f == 0 && i == 5)  blank_req = 1'b1;
         if (f == 0 && i == 8)  blank_req = 1'b0;
         if (f == 0 && i == 50) brightness = 2'd0;
         if (f == 0 && i == 95) seg_in = {7'h11, 7'h22, 7'h33, 7'h44, 7'h55, 7'h66};
         if (f == 1 && i == 10) colon_in = 1'b0;
         if (f == 1 && i == 50) brightness = 2'd2;
         if (f == 1 && i == 53) seg_in[20:14] = 7'h4B;
         if (f == 2 && i == 50) brightness = 2'd1;
         if (f == 2 && i == 95) begin
            blink_mask  = 6'b001100;
            blink_phase = 1'b0;
         end
         if (f == 3 && i == 95) blink_phase = 1'b1;
         @(negedge clk);
      end
   endtask

   // Compare the captured frame against an independent per-cycle expectation.
   task automatic check_frame(input int n_on, input logic [5:0] dark, input int blank_lo,
                              input int blank_hi, input logic colon_exp);
      logic [5:0] e_dig;
      int s;
      int c;
      int on_cnt;
      on_cnt = 0;
      for (int i = 0; i < 96; i++) begin
         s = i / 16;
         c = i % 16;
         e_dig = 6'd0;
         if (c >= 2 && c < 2 + n_on && !dark[5 - s] && !(i >= blank_lo && i <= blank_hi))
            e_dig = 6'b100000 >> s;
         chk("dig_en", i, 64'(cap_dig[i]), 64'(e_dig));
         chk("seg_out", i, 64'(cap_seg[i]), 64'(exp_seg[s]));
         chk("colon_out", i, 64'(cap_col[i]), 64'(colon_exp & e_dig[4]));
         chk("frame_start", i, 64'(cap_fs[i]), 64'(i == 0));
         if (cap_dig[i][0]) on_cnt++;
      end
      chk("s0_on_len", 0, 64'(on_cnt), dark[0] ? 64'd0 : 64'(n_on));
   endtask

   initial begin
      rst         = 1'b1;
      seg_in      = {42{1'b1}};
      colon_in    = 1'b1;
      brightness  = 2'd3;
      blink_mask  = 6'd0;
      blink_phase = 1'b1;
      blank_req   = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_seg", 0, 64'(seg_out), 64'd0);
      chk("rst_dig", 0, 64'(dig_en), 64'd0);
      chk("rst_colon", 0, 64'(colon_out), 64'd0);
      chk("rst_fs", 0, 64'(frame_start), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      // Frame 0: full brightness, blank pulse in h1, colon lit in slot 1.
      for (int k = 0; k < 6; k++) exp_seg[k] = 7'h7F;
      run_frame(0);
      check_frame(14, 6'b000000, 6, 8, 1'b1);
      chk("f0_t0_2", 2, 64'(cap_dig[2]), 64'h20);
      chk("f0_t0_15", 15, 64'(cap_dig[15]), 64'h20);
      chk("f0_t0_16", 16, 64'(cap_dig[16]), 64'h00);
      chk("f0_t0_18", 18, 64'(cap_dig[18]), 64'h10);
      chk("f0_col31", 31, 64'(cap_col[31]), 64'd1);
      chk("f0_col32", 32, 64'(cap_col[32]), 64'd0);

      // Frame 1: brightness 0 -> 3 ON cycles; colon sampled low; m0 change mid-slot.
      exp_seg[0] = 7'h11; exp_seg[1] = 7'h22; exp_seg[2] = 7'h33;
      exp_seg[3] = 7'h44; exp_seg[4] = 7'h55; exp_seg[5] = 7'h66;
      chk("f1_fs_next", 0, 64'(frame_start), 64'd1);
      run_frame(1);
      check_frame(3, 6'b000000, -1, -1, 1'b0);
      chk("f1_m0_old", 63, 64'(cap_seg[63]), 64'h44);

      // Frame 2: brightness 2 -> 10 ON cycles; new m0 visible.
      exp_seg[3] = 7'h4B;
      run_frame(2);
      check_frame(10, 6'b000000, -1, -1, 1'b0);
      chk("f2_m0_new", 48, 64'(cap_seg[48]), 64'h4B);
      chk("f2_on_end", 11, 64'(cap_dig[11]), 64'h20);
      chk("f2_off", 12, 64'(cap_dig[12]), 64'h00);

      // Frame 3: brightness 1 -> 7 ON cycles; m1/m0 blinked dark.
      run_frame(3);
      check_frame(7, 6'b001100, -1, -1, 1'b0);

      // Frame 4: blink phase high, all digits lit.
      run_frame(4);
      check_frame(7, 6'b000000, -1, -1, 1'b0);

      // Frame 5: one-cycle reset at slot 4 c = 9 restarts the scan.
      for (int i = 0; i < 82; i++) begin
         chk("onehot0_rst", i, 64'($onehot0(dig_en)), 64'd1);
         if (i == 72) chk("pre_rst_dig", i, 64'(dig_en), 64'h02);
         if (i == 73) begin
            chk("pre_rst_off", i, 64'(dig_en), 64'h00);
            rst = 1'b1;
         end
         if (i == 74) begin
            chk("mid_rst_seg", i, 64'(seg_out), 64'd0);
            chk("mid_rst_dig", i, 64'(dig_en), 64'd0);
            chk("mid_rst_fs", i, 64'(frame_start), 64'd0);
            rst = 1'b0;
         end
         if (i == 75) begin
            chk("post_rst_fs", i, 64'(frame_start), 64'd1);
            chk("post_rst_seg", i, 64'(seg_out), 64'h11);
            chk("post_rst_dig", i, 64'(dig_en), 64'd0);
         end
         if (i == 76) chk("post_rst_fs_pulse", i, 64'(frame_start), 64'd0);
         if (i == 77) chk("post_rst_on", i, 64'(dig_en), 64'h20);
         if (i == 84 - 1) chk("post_rst_on_last", i, 64'(dig_en), 64'h20);
         @(negedge clk);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/display_scan_controller.md
DISPLAY_SCAN_CONTROLLER -- requirements
Module: display_scan_controller

Interface
REQ-001: Parameter SCAN_DIV, default 16, clock cycles per digit slot; SHALL satisfy SCAN_DIV >= BLANK_CYCLES+4.
REQ-002: Parameter BLANK_CYCLES, default 2, anti-ghosting guard cycles at the start of each slot; SHALL be >= 1.
REQ-003: clk  input  1  system clock; the block SHALL use this one clock only.
REQ-004: rst  input  1  reset; SHALL be synchronous and active-high.
REQ-005: seg_in  input  42  segment patterns {h1,h0,m1,m0,s1,s0}, 7 bits each, h1 in [41:35].
REQ-006: colon_in  input  1  colon request.
REQ-007: brightness  input  2  0 = dimmest, 3 = brightest.
REQ-008: blink_mask  input  6  per-digit blink enable; bit 5 = h1 … bit 0 = s0.
REQ-009: blink_phase  input  1  blink phase level; 0 = blinking digits dark.
REQ-010: blank_req  input  1  force all digits dark.
REQ-011: seg_out  output  7  shared segment bus.
REQ-012: colon_out  output  1  colon drive; shares the h0 digit common.
REQ-013: dig_en  output  6  one-hot-or-zero digit common enable; bit mapping as blink_mask.
REQ-014: frame_start  output  1  one-cycle pulse on output cycle 0 of slot 0.

Function
REQ-015: All outputs SHALL be registered.
REQ-016: Slot s (0..5) scans h1,h0,m1,m0,s1,s0 in order and drives dig_en[5-s]. Each slot SHALL last exactly SCAN_DIV output cycles, c = 0..SCAN_DIV-1.
REQ-017: After slot 5 c = SCAN_DIV-1, the scan SHALL wrap to slot 0 c = 0, giving a frame period of 6*SCAN_DIV cycles.
REQ-018: The per-slot FSM SHALL have the states GUARD, ON and OFF.
REQ-019: GUARD: c < BLANK_CYCLES, dig_en = 0.
REQ-020: ON: BLANK_CYCLES <= c < BLANK_CYCLES+N, digit enabled.
REQ-021: OFF: remaining cycles, dig_en = 0.
REQ-022: W = SCAN_DIV-BLANK_CYCLES. N = floor(W*(brightness_s+1)/4), computed with width sufficient for no overflow.
REQ-023: brightness_s SHALL be brightness sampled at the edge producing slot 0 c = 0 and held for the whole frame.
REQ-024: If N = 0, the FSM SHALL go GUARD -> OFF directly.
REQ-025: seg_out SHALL hold the slot's 7-bit pattern, sampled from seg_in at the edge producing c = 0, for the entire slot, including GUARD and OFF. Mid-slot seg_in changes SHALL NOT appear until the next slot.
REQ-026: colon_out SHALL equal colon_in (sampled like seg_in) ANDed with dig_en[4] while slot 1 is active; otherwise it SHALL be 0.
REQ-027: Blink: if blink_mask[5-s] = 1 and blink_phase = 0 (sampled at c = 0), dig_en SHALL stay 0 for that whole slot; timing and seg_out are unaffected.
REQ-028: blank_req = 1 SHALL force dig_en = 0 and colon_out = 0 from the next output cycle. The scan counters SHALL keep running. On release, outputs SHALL resume per the current state.
REQ-029: At most one dig_en bit SHALL be high in any cycle. A slot transition SHALL never show two enables or a new pattern with the old enable, which the GUARD state guarantees.
REQ-030: frame_start SHALL pulse regardless of blank_req and blink.

Reset
REQ-031: While rst = 1, the block SHALL drive seg_out = 0, dig_en = 0, colon_out = 0 and frame_start = 0; slot = 0, c = 0, state = GUARD; brightness_s = 0.
REQ-032: On the first cycle after rst deasserts, outputs SHALL show slot 0 c = 0 with frame_start = 1.
REQ-033: rst asserted mid-slot SHALL take effect at the next edge, abort the slot, and restart per REQ-031 and REQ-032.

Verification
REQ-034: Defaults, brightness = 3, seg_in = all-ones, release rst -> frame_start at t0; dig_en = 6'b100000 for t0+2..t0+15 (14 cycles); 6'b010000 from t0+18; next frame_start at t0+96.
REQ-035: brightness = 0, 2, 1 over successive frames -> ON lengths of 3, 10 and 7 cycles per slot. A brightness change mid-frame SHALL be ignored until the next frame.
REQ-036: blink_mask = 6'b001100, blink_phase = 0 -> dig_en[3] and dig_en[2] never high, while other slots are unchanged. With blink_phase = 1, all six slots are lit.
REQ-037: Change seg_in m0 at slot 3 c = 5 -> seg_out keeps the old m0 through slot 3 and shows the new m0 at the next frame's slot 3.
REQ-038: blank_req pulsed for 3 cycles during h1 ON -> dig_en = 0 for exactly those 3 following cycles, then resumes. colon_in = 1 -> colon_out high only during the slot 1 ON cycles.
REQ-039: Assert rst at slot 4 c = 9 for 1 cycle -> all outputs 0, then frame_start with slot 0 restarted. The bench SHALL check the one-hot-or-zero dig_en property throughout.
